seg_scan_controller: RTL and testbench

Time-multiplexes the board's active-low seven-segment display across NUM_DIGITS digits for the Morse code interpreter. An internal prescaler produces a synchronous per-digit slot, so no derived clock is used. Each slot starts with an anti-ghosting blanking interval. Character codes from the decoder are double-buffered through a valid/ready handshake and committed only at frame boundaries. The block sits between the Morse decoder's character buffer and the board pins.

---
 rtl/seg_scan_pkg.sv | 67 ++++++
 rtl/seg_scan_controller_if.sv | 16 +
 rtl/char_to_seg.sv | 14 +
 rtl/seg_scan_controller.sv | 136 +++++++++++++
 tb/tb_seg_scan_controller.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// seg_scan_pkg : character codes, scan states and 7-seg glyph table
// Rev 1.0
// ============================================================================
package seg_scan_pkg;

    localparam logic [5:0] CH_BLANK       = 6'd63;
    localparam logic [5:0] CH_DASH        = 6'd36;
    localparam logic [5:0] CH_LETTER_BASE = 6'd10;
    localparam logic [6:0] SEG_OFF        = 7'h7F;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a}; letters are best-effort shapes.
    function automatic logic [6:0] seg_glyph(input logic [5:0] code);
        logic [6:0] g;
        g = SEG_OFF;
        case (code)
            6'd0:                   g = 7'h40;
            6'd1:                   g = 7'h79;
            6'd2:                   g = 7'h24;
            6'd3:                   g = 7'h30;
            6'd4:                   g = 7'h19;
            6'd5:                   g = 7'h12;
            6'd6:                   g = 7'h02;
            6'd7:                   g = 7'h78;
            6'd8:                   g = 7'h00;
            6'd9:                   g = 7'h10;
            CH_LETTER_BASE + 6'd0:  g = 7'h08;
            CH_LETTER_BASE + 6'd1:  g = 7'h03;
            CH_LETTER_BASE + 6'd2:  g = 7'h46;
            CH_LETTER_BASE + 6'd3:  g = 7'h21;
            CH_LETTER_BASE + 6'd4:  g = 7'h06;
            CH_LETTER_BASE + 6'd5:  g = 7'h0E;
            CH_LETTER_BASE + 6'd6:  g = 7'h42;
            CH_LETTER_BASE + 6'd7:  g = 7'h09;
            CH_LETTER_BASE + 6'd8:  g = 7'h4F;
            CH_LETTER_BASE + 6'd9:  g = 7'h61;
            CH_LETTER_BASE + 6'd10: g = 7'h0A;
            CH_LETTER_BASE + 6'd11: g = 7'h47;
            CH_LETTER_BASE + 6'd12: g = 7'h6A;
            CH_LETTER_BASE + 6'd13: g = 7'h2B;
            CH_LETTER_BASE + 6'd14: g = 7'h23;
            CH_LETTER_BASE + 6'd15: g = 7'h0C;
            CH_LETTER_BASE + 6'd16: g = 7'h18;
            CH_LETTER_BASE + 6'd17: g = 7'h2F;
            CH_LETTER_BASE + 6'd18: g = 7'h12;
            CH_LETTER_BASE + 6'd19: g = 7'h07;
            CH_LETTER_BASE + 6'd20: g = 7'h41;
            CH_LETTER_BASE + 6'd21: g = 7'h63;
            CH_LETTER_BASE + 6'd22: g = 7'h55;
            CH_LETTER_BASE + 6'd23: g = 7'h09;
            CH_LETTER_BASE + 6'd24: g = 7'h11;
            CH_LETTER_BASE + 6'd25: g = 7'h24;
            CH_DASH:                g = 7'h3F;
            CH_BLANK:               g = SEG_OFF;
            default:                g = SEG_OFF;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_controller_if.sv
`default_nettype none
// ============================================================================
// seg_scan_controller_if : valid/ready frame-update channel
// Rev 1.0
// ============================================================================
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    upd_valid;
    logic                    upd_ready;
    logic [6*NUM_DIGITS-1:0] upd_chars;

    modport master (output upd_valid, output upd_chars, input  upd_ready);
    modport slave  (input  upd_valid, input  upd_chars, output upd_ready);
endinterface
`default_nettype wire

// File: rtl/char_to_seg.sv
`default_nettype none
// ============================================================================
// char_to_seg : combinational 6-bit character code to active-low glyph
// Rev 1.0
// ============================================================================
module char_to_seg
    import seg_scan_pkg::*;
(
    input  logic [5:0] code,
    output logic [6:0] glyph
);
    assign glyph = seg_glyph(code);
endmodule
`default_nettype wire

// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
// seg_scan_controller : multiplexed 7-seg scanner with blanking and
//                       frame-boundary double-buffered updates
// Rev 1.0
// ============================================================================
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_controller_if.slave  upd,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         c_slot_last  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]         c_blank      = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0]         c_digit_last = DW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_one     = NUM_DIGITS'(1);
    localparam scan_state_t           c_state_rst  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    logic [CW-1:0]         r_slot_cnt;
    logic [CW-1:0]         w_slot_next;
    logic [DW-1:0]         r_digit_idx;
    logic                  w_slot_wrap;
    scan_state_t           r_state;
    scan_state_t           w_state_next;
    logic [5:0]            r_active [NUM_DIGITS];
    logic [5:0]            r_shadow [NUM_DIGITS];
    logic                  r_pending;
    logic                  w_accept;
    logic                  w_commit;
    logic [5:0]            w_code;
    logic [6:0]            w_glyph;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [6:0]            w_seg_next;

    assign w_slot_wrap   = (r_slot_cnt == c_slot_last);
    assign w_slot_next   = w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
    assign frame_done    = w_slot_wrap && (r_digit_idx == c_digit_last);
    assign upd.upd_ready = !r_pending;
    assign w_accept      = upd.upd_valid && !r_pending;
    // Commit only ever coincides with pending, so accept and commit are exclusive.
    assign w_commit      = frame_done && r_pending;
    assign w_code        = r_active[r_digit_idx];

    char_to_seg u_char_to_seg (
        .code  (w_code),
        .glyph (w_glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else begin
            r_slot_cnt <= w_slot_next;
            if (w_slot_wrap) begin
                r_digit_idx <= (r_digit_idx == c_digit_last) ? '0 : r_digit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_state_rst;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_state always describes the current slot_cnt; outputs register it one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_an_next    = '1;
        w_seg_next   = seg;
        case (r_state)
            ST_BLANK: begin
                if (w_slot_next >= c_blank) begin
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_an_next  = ~(c_an_one << r_digit_idx);
                w_seg_next = w_glyph;
                if (w_slot_wrap && (c_blank != '0)) begin
                    w_state_next = ST_BLANK;
                end
            end
            default: w_state_next = c_state_rst;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= w_an_next;
            seg <= w_seg_next;
            dp  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_active[i] <= CH_BLANK;
                r_shadow[i] <= CH_BLANK;
            end
            r_pending <= 1'b0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_active[i] <= r_shadow[i];
            end
            r_pending <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= upd.upd_chars[6*i +: 6];
            end
            r_pending <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_controller : randomized bench against a frame-level display model
// Rev 1.0
// ============================================================================
module tb_seg_scan_controller;
    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    localparam logic [6:0] GLYPHS [37] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h4F, 7'h61,
        7'h0A, 7'h47, 7'h6A, 7'h2B, 7'h23, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07,
        7'h41, 7'h63, 7'h55, 7'h09, 7'h11, 7'h24, 7'h3F
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         frame_done;

    always #5 clk = ~clk;

    seg_scan_controller_if #(.NUM_DIGITS(N)) upd_if ();

    seg_scan_controller #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd        (upd_if),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: cycle number since reset release, displayed frame, buffered frame.
    int         m_n;
    logic [5:0] m_active [N];
    logic [5:0] m_shadow [N];
    bit         m_pending;
    logic [N-1:0] m_an;
    logic [6:0] m_seg;
    bit         m_acc, m_commit;
    int         m_accept_n, m_commit_n;

    function automatic logic [6:0] ref_glyph(input logic [5:0] code);
        if (code <= 6'd36) return GLYPHS[code];
        return 7'h7F;
    endfunction

    function automatic bit fd_now();
        return ((m_n % R) == R - 1) && (((m_n / R) % N) == N - 1);
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_an, m_seg, 1'b1, fd_now(), !m_pending};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {an, seg, dp, frame_done, upd_if.upd_ready};
    endfunction

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < N; i++) begin
            m_active[i] = 6'd63;
            m_shadow[i] = 6'd63;
        end
        m_pending = 0;
        m_an  = '1;
        m_seg = 7'h7F;
    endtask

    task automatic step();
        int c, d;
        bit fd;
        @(posedge clk);
        c  = m_n % R;
        d  = (m_n / R) % N;
        fd = fd_now();
        m_acc = 0;
        m_commit = 0;
        for (int k = 0; k < N; k++) m_an[k] = !(c >= B && k == d);
        if (c >= B) m_seg = ref_glyph(m_active[d]);
        if (fd && m_pending) begin
            for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
            m_pending = 0;
            m_commit = 1;
            m_commit_n = m_n;
        end else if (upd_if.upd_valid && !m_pending) begin
            for (int i = 0; i < N; i++) m_shadow[i] = upd_if.upd_chars[6*i +: 6];
            m_pending = 1;
            m_acc = 1;
            m_accept_n = m_n;
        end
        m_n++;
        #1;
    endtask

    task automatic test_reset();
        upd_if.upd_valid = 1'b0;
        upd_if.upd_chars = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_outputs got %b exp %b", {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        else n_pass++;
        rst = 1'b0;
        model_reset();
        n_total++;
        if (upd_if.upd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", upd_if.upd_ready);
        else n_pass++;
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done);
        else n_pass++;
    endtask

    task automatic test_idle_scan();
        int fd_count = 0;
        for (int i = 0; i < 2 * N * R; i++) begin
            step();
            if (frame_done === 1'b1) fd_count++;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL idle_scan n=%0d got %b exp %b", m_n, dut_vec(), exp_vec());
            else n_pass++;
            n_total++;
            if ($countones(~an) > 1 || (((m_n - 1) % R) < B && an !== '1))
                $display("FAIL idle_ghost n=%0d got an=%b", m_n, an);
            else n_pass++;
        end
        n_total++;
        if (fd_count != 2) $display("FAIL idle_frame_count got %0d exp 2", fd_count);
        else n_pass++;
    endtask

    task automatic test_load_e510();
        bit seen_commit = 0;
        upd_if.upd_chars = {6'd14, 6'd5, 6'd1, 6'd0};
        upd_if.upd_valid = 1'b1;
        step();
        n_total++;
        if (upd_if.upd_ready !== 1'b0) $display("FAIL e510_accept got ready=%b exp 0", upd_if.upd_ready);
        else n_pass++;
        upd_if.upd_valid = 1'b0;
        for (int i = 0; i < 3 * N * R; i++) begin
            step();
            if (m_commit) seen_commit = 1;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL e510_scan n=%0d got %b exp %b", m_n, dut_vec(), exp_vec());
            else n_pass++;
            if (seen_commit && m_n == m_commit_n + 1) begin
                n_total++;
                if (upd_if.upd_ready !== 1'b1) $display("FAIL e510_ready_return got %b exp 1", upd_if.upd_ready);
                else n_pass++;
            end
            if (seen_commit && m_n == m_commit_n + B + 2) begin
                n_total++;
                if ({an, seg} !== {4'b1110, 7'h40})
                    $display("FAIL e510_first_glyph got an=%b seg=%h exp an=1110 seg=40", an, seg);
                else n_pass++;
                break;
            end
        end
        n_total++;
        if (!seen_commit) $display("FAIL e510_commit_timeout got none exp commit");
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got_a = 0, got_b = 0;
        upd_if.upd_chars = 24'($urandom);
        upd_if.upd_valid = 1'b1;
        for (int i = 0; i < 4 && !got_a; i++) begin
            step();
            got_a = m_acc;
        end
        upd_if.upd_chars = 24'($urandom);
        for (int i = 0; i < 3 * N * R && got_a && !got_b; i++) begin
            step();
            got_b = m_acc;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL b2b_scan n=%0d got %b exp %b", m_n, dut_vec(), exp_vec());
            else n_pass++;
        end
        upd_if.upd_valid = 1'b0;
        n_total++;
        if (!(got_a && got_b) || m_accept_n != m_commit_n + 1)
            $display("FAIL b2b_accept_after_commit got accept=%0d exp %0d (a=%0d b=%0d)",
                     m_accept_n, m_commit_n + 1, got_a, got_b);
        else n_pass++;
        for (int i = 0; i < 2 * N * R; i++) begin
            step();
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL b2b_drain n=%0d got %b exp %b", m_n, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_codes();
        bit committed = 0, chk50 = 0, chk36 = 0;
        upd_if.upd_chars = {6'd63, 6'($urandom_range(9, 0)), 6'd36, 6'd50};
        upd_if.upd_valid = 1'b1;
        step();
        upd_if.upd_valid = 1'b0;
        for (int i = 0; i < 3 * N * R && !(chk50 && chk36); i++) begin
            step();
            if (m_commit) committed = 1;
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL codes_scan n=%0d got %b exp %b", m_n, dut_vec(), exp_vec());
            else n_pass++;
            if (committed && !chk50 && m_an == 4'b1110) begin
                chk50 = 1;
                n_total++;
                if (seg !== 7'h7F) $display("FAIL code50_glyph got %h exp 7f", seg);
                else n_pass++;
            end
            if (committed && !chk36 && m_an == 4'b1101) begin
                chk36 = 1;
                n_total++;
                if (seg !== 7'h3F) $display("FAIL code36_glyph got %h exp 3f", seg);
                else n_pass++;
            end
        end
        n_total++;
        if (!(chk50 && chk36)) $display("FAIL codes_timeout got %0d%0d exp 11", chk50, chk36);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step();
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random_scan n=%0d got %b exp %b", m_n, dut_vec(), exp_vec());
            else n_pass++;
            n_total++;
            if ($countones(~an) > 1 || (((m_n - 1) % R) < B && an !== '1))
                $display("FAIL random_ghost n=%0d got an=%b", m_n, an);
            else n_pass++;
            // A source keeps its offer stable until it is taken.
            if (!upd_if.upd_valid || m_acc) begin
                upd_if.upd_valid = ($urandom_range(2, 0) == 0);
                upd_if.upd_chars = 24'($urandom);
            end
        end
        upd_if.upd_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok = 0;
        for (int i = 0; i < N * R + 1 && (m_n % (N * R)) != 0; i++) step();
        upd_if.upd_chars = 24'($urandom);
        upd_if.upd_valid = 1'b1;
        step();
        upd_if.upd_valid = 1'b0;
        for (int i = 0; i < R; i++) begin
            if ((m_n % R) == 4 && m_pending) begin
                ok = 1;
                break;
            end
            step();
        end
        n_total++;
        if (!ok || an === '1) $display("FAIL areset_setup got pending=%0d an=%b exp driving", m_pending, an);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if ({an, seg} !== {4'hF, 7'h7F}) $display("FAIL areset_immediate got an=%b seg=%h exp an=1111 seg=7f", an, seg);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        n_total++;
        if (upd_if.upd_ready !== 1'b1) $display("FAIL areset_ready got %b exp 1", upd_if.upd_ready);
        else n_pass++;
        for (int i = 0; i < N * R + B + 2; i++) begin
            step();
            n_total++;
            if (dut_vec() !== exp_vec())
                $display("FAIL areset_scan n=%0d got %b exp %b", m_n, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_e510();
        test_back_to_back();
        test_codes();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
